// File: rtl/pausable_bcd_counter_pkg.sv
// Shared types and constants for the pausable two-digit BCD counter.
// Holds the active-low 7-segment codes, the digit enables and the BCD digit type.
package pausable_bcd_counter_pkg;

   typedef logic [3:0] bcd_t;

   // Segment order {g,f,e,d,c,b,a}, active-low
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low digit enables
   localparam logic [1:0] AN_ONES = 2'b10;
   localparam logic [1:0] AN_TENS = 2'b01;

endpackage

// File: rtl/pausable_bcd_counter_seg7.sv
// bcd_to_seg7: combinational BCD to active-low 7-segment decoder.
// Ports: bcd (4-bit digit in), seg (7-bit {g,f,e,d,c,b,a} out); non-BCD codes blank.
module bcd_to_seg7
   import pausable_bcd_counter_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/pausable_bcd_counter.sv
// Two-digit BCD counter with level pause, sync clear, wrap at MAX_COUNT and a
// 2-digit multiplexed active-low 7-seg display; dp low while paused.
// Ports: clk, rst_n (async, active-low), pause, clear, [dir], ones, tens,
// tick, carry, an, seg, dp. Macro COUNT_DIR_EN adds input dir (1=up, 0=down).
module pausable_bcd_counter
   import pausable_bcd_counter_pkg::*;
#(
   parameter int CLK_DIV   = 50_000_000,
   parameter int MAX_COUNT = 59,
   parameter int SCAN_DIV  = 50_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pause,
   input  logic       clear,
`ifdef COUNT_DIR_EN
   input  logic       dir,
`endif
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic       tick,
   output logic       carry,
   output logic [1:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int SCAN_W = $clog2(SCAN_DIV);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   localparam bcd_t MAX_TENS = 4'(MAX_COUNT / 10);
   localparam bcd_t MAX_ONES = 4'(MAX_COUNT % 10);

   logic [DIV_W-1:0]  div_cnt;
   logic [SCAN_W-1:0] scan_cnt;
   logic              step;
   logic              up;
   logic              wrap;
   bcd_t              nxt_ones;
   bcd_t              nxt_tens;
   bcd_t              digit;

   // A paused prescaler holds, so a partial period resumes where it left off
   assign step = (div_cnt == DIV_LAST) && !pause;

`ifdef COUNT_DIR_EN
   assign up = dir;
`else
   assign up = 1'b1;
`endif

   always_comb begin
      nxt_ones = ones;
      nxt_tens = tens;
      wrap     = 1'b0;
      if (up) begin
         if (tens == MAX_TENS && ones == MAX_ONES) begin
            nxt_ones = 4'd0;
            nxt_tens = 4'd0;
            wrap     = 1'b1;
         end else if (ones == 4'd9) begin
            nxt_ones = 4'd0;
            nxt_tens = tens + 4'd1;
         end else begin
            nxt_ones = ones + 4'd1;
         end
      end else begin
         // Borrow out of 00 reloads the terminal count
         if (tens == 4'd0 && ones == 4'd0) begin
            nxt_ones = MAX_ONES;
            nxt_tens = MAX_TENS;
            wrap     = 1'b1;
         end else if (ones == 4'd0) begin
            nxt_ones = 4'd9;
            nxt_tens = tens - 4'd1;
         end else begin
            nxt_ones = ones - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (clear || step) begin
         div_cnt <= '0;
      end else if (!pause) begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones  <= 4'd0;
         tens  <= 4'd0;
         tick  <= 1'b0;
         carry <= 1'b0;
      end else if (clear) begin
         ones  <= 4'd0;
         tens  <= 4'd0;
         tick  <= 1'b0;
         carry <= 1'b0;
      end else begin
         tick  <= step;
         carry <= step && wrap;
         if (step) begin
            ones <= nxt_ones;
            tens <= nxt_tens;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp <= 1'b1;
      end else begin
         dp <= ~pause;
      end
   end

   // Display scan is free-running: unaffected by pause and clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         an       <= AN_ONES;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         an       <= (an == AN_ONES) ? AN_TENS : AN_ONES;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   assign digit = (an == AN_ONES) ? ones : tens;

   bcd_to_seg7 u_seg (
      .bcd (digit),
      .seg (seg)
   );

endmodule

// File: tb/tb_pausable_bcd_counter.sv
// Directed testbench for pausable_bcd_counter (CLK_DIV=4, MAX_COUNT=59, SCAN_DIV=8).
// Define COUNT_DIR_EN to also exercise the down-count path.
module tb_pausable_bcd_counter;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       pause = 1'b0;
   logic       clear = 1'b0;
`ifdef COUNT_DIR_EN
   logic       dir   = 1'b1;
`endif
   logic [3:0] ones;
   logic [3:0] tens;
   logic       tick;
   logic       carry;
   logic [1:0] an;
   logic [6:0] seg;
   logic       dp;

   int checks = 0;
   int errors = 0;

   localparam logic [15:0] RST_VEC = {4'd0, 4'd0, 1'b0, 1'b0, 2'b10, 7'b1000000, 1'b1};

   pausable_bcd_counter #(
      .CLK_DIV   (4),
      .MAX_COUNT (59),
      .SCAN_DIV  (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pause (pause),
      .clear (clear),
`ifdef COUNT_DIR_EN
      .dir   (dir),
`endif
      .ones  (ones),
      .tens  (tens),
      .tick  (tick),
      .carry (carry),
      .an    (an),
      .seg   (seg),
      .dp    (dp)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic run_edges(input int n);
      repeat (n) cyc();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pause = 1'b0;
      clear = 1'b0;
`ifdef COUNT_DIR_EN
      dir = 1'b1;
`endif
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc();
      checks++;
      if ({ones, tens, tick, carry, an, seg, dp} !== RST_VEC) begin
         errors++;
         $display("FAIL reset_outputs got %h want %h",
                  {ones, tens, tick, carry, an, seg, dp}, RST_VEC);
      end
      checks++;
      if (dut.div_cnt !== 2'd0) begin
         errors++;
         $display("FAIL reset_div_cnt got %0d want 0", dut.div_cnt);
      end
   endtask

   task automatic test_count();
      int ticks;
      ticks = 0;
      do_reset();
      for (int i = 1; i <= 40; i++) begin
         cyc();
         if (tick) ticks++;
         if (i == 3) begin
            checks++;
            if ({tick, tens, ones} !== {1'b0, 8'h00}) begin
               errors++;
               $display("FAIL count_edge3 got %h want %h", {tick, tens, ones}, {1'b0, 8'h00});
            end
         end
         if (i == 4) begin
            checks++;
            if ({tick, tens, ones} !== {1'b1, 8'h01}) begin
               errors++;
               $display("FAIL count_first_tick got %h want %h", {tick, tens, ones}, {1'b1, 8'h01});
            end
         end
      end
      checks++;
      if ({tens, ones} !== 8'h10) begin
         errors++;
         $display("FAIL count_40_edges got %h want 10", {tens, ones});
      end
      checks++;
      if (ticks != 10) begin
         errors++;
         $display("FAIL count_tick_total got %0d want 10", ticks);
      end
   endtask

   task automatic test_wrap();
      int exp_v, bad, carries, carry_step, steps, carry_no_tick;
      logic [7:0] expv;
      exp_v = 0; bad = 0; carries = 0; carry_step = -1;
      steps = 0; carry_no_tick = 0;
      do_reset();
      for (int i = 1; i <= 240; i++) begin
         cyc();
         if (carry && !tick) carry_no_tick++;
         if (tick) begin
            steps++;
            exp_v = (exp_v == 59) ? 0 : exp_v + 1;
            expv = {4'(exp_v / 10), 4'(exp_v % 10)};
            if ({tens, ones} !== expv) bad++;
            if (carry) begin
               carries++;
               carry_step = steps;
            end
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wrap_sequence got %0d bad steps want 0", bad);
      end
      checks++;
      if (carries != 1 || carry_step != 60) begin
         errors++;
         $display("FAIL wrap_carry got %0d carries at step %0d want 1 at step 60",
                  carries, carry_step);
      end
      checks++;
      if (carry_no_tick != 0) begin
         errors++;
         $display("FAIL wrap_carry_tick got %0d lone carries want 0", carry_no_tick);
      end
      checks++;
      if ({tens, ones, tick, carry} !== {8'h00, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL wrap_value got %h want %h", {tens, ones, tick, carry}, {8'h00, 2'b11});
      end
      cyc();
      checks++;
      if (carry !== 1'b0) begin
         errors++;
         $display("FAIL wrap_carry_pulse got %b want 0", carry);
      end
   endtask

   task automatic test_pause();
      int bad;
      bad = 0;
      do_reset();
      run_edges(6);
      checks++;
      if ({tens, ones, dut.div_cnt} !== {8'h01, 2'd2}) begin
         errors++;
         $display("FAIL pause_setup got %h want %h", {tens, ones, dut.div_cnt}, {8'h01, 2'd2});
      end
      pause = 1'b1;
      #1;
      checks++;
      if (dp !== 1'b1) begin
         errors++;
         $display("FAIL pause_dp_lag got %b want 1", dp);
      end
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (dut.div_cnt !== 2'd2 || tick !== 1'b0 || {tens, ones} !== 8'h01) bad++;
         if (i == 1) begin
            checks++;
            if (dp !== 1'b0) begin
               errors++;
               $display("FAIL pause_dp got %b want 0", dp);
            end
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL pause_frozen got %0d bad cycles want 0", bad);
      end
      pause = 1'b0;
      cyc();
      checks++;
      if ({tick, dp} !== 2'b01) begin
         errors++;
         $display("FAIL pause_release1 got %b want 01", {tick, dp});
      end
      cyc();
      checks++;
      if ({tick, tens, ones} !== {1'b1, 8'h02}) begin
         errors++;
         $display("FAIL pause_release2 got %h want %h", {tick, tens, ones}, {1'b1, 8'h02});
      end
   endtask

   task automatic test_clear();
      int bad;
      bad = 0;
      do_reset();
      run_edges(239);
      checks++;
      if ({tens, ones, dut.div_cnt} !== {8'h59, 2'd3}) begin
         errors++;
         $display("FAIL clear_setup got %h want %h", {tens, ones, dut.div_cnt}, {8'h59, 2'd3});
      end
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      checks++;
      if ({tens, ones, tick, carry, dut.div_cnt} !== {8'h00, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL clear_apply got %h want %h",
                  {tens, ones, tick, carry, dut.div_cnt}, {8'h00, 4'h0});
      end
      for (int i = 1; i <= 4; i++) begin
         cyc();
         if (i < 4 && tick) bad++;
         if (i == 4) begin
            checks++;
            if ({tick, tens, ones} !== {1'b1, 8'h01} || bad != 0) begin
               errors++;
               $display("FAIL clear_next_tick got %h (early %0d) want %h",
                        {tick, tens, ones}, bad, {1'b1, 8'h01});
            end
         end
      end
   endtask

   task automatic test_scan();
      int changes, since, bad_int, bad_seg, bad_val;
      logic [1:0] prev;
      logic [6:0] exp_seg;
      changes = 0; since = 0; bad_int = 0; bad_seg = 0; bad_val = 0;
      do_reset();
      run_edges(148);
      checks++;
      if ({tens, ones} !== 8'h37) begin
         errors++;
         $display("FAIL scan_setup got %h want 37", {tens, ones});
      end
      pause = 1'b1;
      prev = an;
      for (int i = 1; i <= 40; i++) begin
         cyc();
         since++;
         if (an !== prev) begin
            changes++;
            if (changes > 1 && since != 8) bad_int++;
            since = 0;
            prev = an;
         end
         exp_seg = (an == 2'b01) ? 7'b0110000 : 7'b1111000;
         if ((an !== 2'b10 && an !== 2'b01) || seg !== exp_seg) bad_seg++;
         if ({tens, ones} !== 8'h37) bad_val++;
      end
      pause = 1'b0;
      checks++;
      if (changes != 5 || bad_int != 0) begin
         errors++;
         $display("FAIL scan_period got %0d toggles (%0d bad gaps) want 5 (0)", changes, bad_int);
      end
      checks++;
      if (bad_seg != 0) begin
         errors++;
         $display("FAIL scan_seg got %0d bad cycles want 0", bad_seg);
      end
      checks++;
      if (bad_val != 0) begin
         errors++;
         $display("FAIL scan_paused_value got %0d bad cycles want 0", bad_val);
      end
   endtask

   task automatic test_async_reset();
      int bad;
      bad = 0;
      do_reset();
      run_edges(93);
      checks++;
      if ({tens, ones} !== 8'h23) begin
         errors++;
         $display("FAIL areset_setup got %h want 23", {tens, ones});
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ones, tens, tick, carry, an, seg, dp} !== RST_VEC || dut.div_cnt !== 2'd0) begin
         errors++;
         $display("FAIL areset_async got %h want %h",
                  {ones, tens, tick, carry, an, seg, dp}, RST_VEC);
      end
      cyc();
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         if (i < 4 && tick) bad++;
         if (i == 4) begin
            checks++;
            if ({tick, tens, ones} !== {1'b1, 8'h01} || bad != 0) begin
               errors++;
               $display("FAIL areset_resume got %h (early %0d) want %h",
                        {tick, tens, ones}, bad, {1'b1, 8'h01});
            end
         end
      end
   endtask

`ifdef COUNT_DIR_EN
   task automatic test_down();
      do_reset();
      dir = 1'b0;
      run_edges(4);
      checks++;
      if ({tens, ones, tick, carry} !== {8'h59, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL down_borrow got %h want %h", {tens, ones, tick, carry}, {8'h59, 2'b11});
      end
      run_edges(4);
      checks++;
      if ({tens, ones, tick, carry} !== {8'h58, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL down_step got %h want %h", {tens, ones, tick, carry}, {8'h58, 2'b10});
      end
      dir = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_count();
      test_wrap();
      test_pause();
      test_clear();
      test_scan();
      test_async_reset();
`ifdef COUNT_DIR_EN
      test_down();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pausable_bcd_counter.md
Name: pausable_bcd_counter

Overview:
- Two-digit BCD counter that sits directly downstream of the key debouncer and consumes its level-type pause flag.
- While the flag is low, the counter advances once every CLK_DIV clocks. While it is high, the counter freezes.
- It wraps at a programmable maximum and drives a 2-digit multiplexed, active-low 7-segment display.
- The decimal point indicates the paused state.

Parameters:
CLK_DIV, 50_000_000, clk cycles per count step (>=2)
MAX_COUNT, 59, terminal count, range 1..99; wraps to 00 after it
SCAN_DIV, 50_000, clk cycles each digit is displayed before switching (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
pause  in  1  level; 1 = frozen (driven by debouncer pause_state)
clear  in  1  synchronous clear, active-high
ones  out  4  BCD units digit
tens  out  4  BCD tens digit
tick  out  1  1-cycle pulse on every count step
carry  out  1  1-cycle pulse when the count wraps MAX_COUNT->00
an  out  2  digit enables, active-low; 2'b10 = ones, 2'b01 = tens
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low; 0 while paused

Behaviour:
- Clock and reset: clk rising edge; reset rst_n, asynchronous, active-low.
- Reset values: div_cnt=0, scan_cnt=0, ones=0, tens=0, tick=0, carry=0, an=2'b10, seg=7'b1000000 ("0"), dp=1.
- Prescaler div_cnt (0..CLK_DIV-1):
  - Increments on each edge with pause=0.
  - Holds its value while pause=1, so a step is not restarted by a pause.
- Step condition: div_cnt==CLK_DIV-1 and pause=0. On that edge:
  - div_cnt becomes 0.
  - The count advances.
  - tick=1 for that one cycle. The digits and tick update on the same edge.
- BCD advance:
  - ones 9->0 with tens+1.
  - At {tens,ones}==MAX_COUNT (MAX_TENS=MAX_COUNT/10, MAX_ONES=MAX_COUNT%10): both digits go to 0 and carry=1 together with tick.
  - Digits never hold a non-BCD value or a value above MAX_COUNT.
- clear has the highest priority below reset:
  - div_cnt, ones, tens become 0; tick and carry become 0. This applies regardless of pause.
  - clear on a wrap edge produces no carry.
- Pause toggling is owned upstream; this block only samples the level. It needs no synchronizer because the debouncer's output is already registered in clk.
- dp is registered as ~pause, so it lags pause by 1 cycle.
- Display scan:
  - scan_cnt runs freely and ignores pause and clear.
  - On scan_cnt==SCAN_DIV-1 it wraps to 0 and an toggles between 2'b10 and 2'b01.
  - seg is the combinational decode of the digit selected by the registered an: ones when an=2'b10, tens otherwise.
- Decode table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other code gives blank 1111111.
- Reset asserted mid-operation forces all reset values immediately. After release, counting resumes from 00 with a full CLK_DIV period.

Optional Feature:
COUNT_DIR_EN:
- With the macro defined, an extra input port dir (1 bit, after clear) is present. dir=1 counts up as above. dir=0 counts down:
  - ones 0->9 with tens-1.
  - 00 -> MAX_COUNT, with carry=1 acting as borrow.
  - dir is sampled on the step edge only.
- Without the macro, the port is absent and the block counts up only.

Decomposition:
- Package pausable_bcd_counter_pkg holds:
  - the SEG_0..SEG_9 and SEG_BLANK constants;
  - AN_ONES=2'b10 and AN_TENS=2'b01;
  - a 4-bit bcd digit typedef.
- Sub-module bcd_to_seg7 is purely combinational: 4-bit BCD in, 7-bit active-low seg out. It is instantiated once on the muxed digit.

Test Plan (CLK_DIV=4, MAX_COUNT=59, SCAN_DIV=8 unless noted):
1. Release reset with pause=0 -> first tick on the 4th edge, value 01. After 40 edges the value is 10, and tick was high exactly 10 cycles.
2. Run 60 steps from 00 -> at step 60 the value is 00, and carry=1 for exactly one cycle, coincident with tick. No carry at 58->59.
3. Assert pause when div_cnt=2 and hold for 20 cycles -> ones/tens/div_cnt frozen, tick=0, dp=0 one cycle later. After release, tick occurs on the 2nd edge with pause=0.
4. At 59 with div_cnt=3, pulse clear for one cycle -> value 00, carry=0, tick=0. The next tick comes 4 edges later, value 01.
5. Hold value 37 with pause=1 -> an alternates every 8 cycles and keeps scanning while paused. seg=0110000 when an=2'b01 and 1111000 when an=2'b10.
6. Drop rst_n asynchronously mid-count at 23 -> outputs take reset values before the next edge. With COUNT_DIR_EN and dir=0 from 00 -> one step gives 59 with carry=1.
